// File: rtl/key_note_decoder.sv
// Key-code receiver: stability filter, single-note tracker with on/off/bad strobes, square-wave tone.
// Strobes and note outputs update STABLE_CYCLES-1 edges after a new level is first sampled; no backpressure.
module key_note_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        k_tr,
  input  logic [7:0]  key_code,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic        note_on,
  output logic        note_off,
  output logic        bad_code,
  output logic [15:0] half_period,
  output logic        tone
);

  localparam logic [7:0] REL_CODE = 8'hF0;

  typedef enum logic {IDLE, HELD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic [15:0] hp_q, hp_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        tone_q, tone_d;
  logic        note_on_q, note_on_d;
  logic        note_off_q, note_off_d;
  logic        bad_q, bad_d;

  logic        map_hit;
  logic [3:0]  map_idx;
  logic [15:0] map_hp;
  logic [8:0]  run_len;
  logic        accept;

  always_comb begin
    map_hit = 1'b1;
    map_idx = 4'd0;
    map_hp  = 16'd0;
    case (key_code)
      8'h2B: begin map_idx = 4'd1; map_hp = 16'd47778; end
      8'h34: begin map_idx = 4'd2; map_hp = 16'd42566; end
      8'h33: begin map_idx = 4'd3; map_hp = 16'd37922; end
      8'h3B: begin map_idx = 4'd4; map_hp = 16'd35793; end
      8'h42: begin map_idx = 4'd5; map_hp = 16'd31888; end
      8'h4B: begin map_idx = 4'd6; map_hp = 16'd28409; end
      8'h4C: begin map_idx = 4'd7; map_hp = 16'd25310; end
      8'h52: begin map_idx = 4'd8; map_hp = 16'd23889; end
      default: map_hit = 1'b0;
    endcase
  end

  // run_len counts matching samples including the one on this edge; cnt_q holds run length minus one.
  always_comb begin
    run_len = (key_code == cand_q) ? ({1'b0, cnt_q} + 9'd2) : 9'd1;
    accept  = (run_len >= 9'(STABLE_CYCLES)) && (key_code != acc_q);
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    note_idx_d = note_idx_q;
    hp_d       = hp_q;
    pcnt_d     = pcnt_q;
    tone_d     = tone_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    bad_d      = 1'b0;

    if (key_code != cand_q) begin
      cand_d = key_code;
      cnt_d  = 8'd0;
    end else if (cnt_q != 8'(STABLE_CYCLES - 1)) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (accept) begin
      acc_d = key_code;
      if (key_code == REL_CODE) begin
        if (state_q == HELD) begin
          state_d    = IDLE;
          note_off_d = 1'b1;
          hp_d       = 16'd0;
        end
      end else if (!map_hit) begin
        bad_d = 1'b1;
      end else if (state_q == IDLE || map_idx != note_idx_q) begin
        // A return to the already-held note (e.g. after a bad code) is not a retrigger.
        note_off_d = (state_q == HELD);
        note_on_d  = 1'b1;
        state_d    = HELD;
        note_idx_d = map_idx;
        hp_d       = map_hp;
      end
    end

    if (state_d == IDLE || note_on_d) begin
      pcnt_d = 16'd0;
      tone_d = 1'b0;
    end else if (pcnt_q == hp_q - 16'd1) begin
      pcnt_d = 16'd0;
      tone_d = ~tone_q;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      state_q    <= IDLE;
      cand_q     <= REL_CODE;
      cnt_q      <= 8'd0;
      acc_q      <= REL_CODE;
      note_idx_q <= 4'd0;
      hp_q       <= 16'd0;
      pcnt_q     <= 16'd0;
      tone_q     <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      note_idx_q <= note_idx_d;
      hp_q       <= hp_d;
      pcnt_q     <= pcnt_d;
      tone_q     <= tone_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      bad_q      <= bad_d;
    end
  end

  assign note_valid  = (state_q == HELD);
  assign note_idx    = note_idx_q;
  assign note_on     = note_on_q;
  assign note_off    = note_off_q;
  assign bad_code    = bad_q;
  assign half_period = hp_q;
  assign tone        = tone_q;

endmodule

// File: tb/tb_key_note_decoder.sv
// Bench for key_note_decoder: directed scenarios plus random key-code levels against a behavioural model.
module tb_key_note_decoder;

  localparam int SC = 4;
  localparam logic [7:0] CODES [8] = '{8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52};
  localparam int HPS [8] = '{47778, 42566, 37922, 35793, 31888, 28409, 25310, 23889};

  logic        clock = 1'b0;
  logic        k_tr;
  logic [7:0]  key_code;
  logic        note_valid;
  logic [3:0]  note_idx;
  logic        note_on;
  logic        note_off;
  logic        bad_code;
  logic [15:0] half_period;
  logic        tone;

  int checks = 0;
  int errors = 0;

  key_note_decoder #(.STABLE_CYCLES(SC)) dut (
    .clock      (clock),
    .k_tr       (k_tr),
    .key_code   (key_code),
    .note_valid (note_valid),
    .note_idx   (note_idx),
    .note_on    (note_on),
    .note_off   (note_off),
    .bad_code   (bad_code),
    .half_period(half_period),
    .tone       (tone)
  );

  always #10 clock = ~clock;

  // Reference model: run length of identical samples, last accepted value, held note and
  // time since its note_on; tone is the parity of elapsed whole half-periods.
  int          m_run, m_idx, m_hp, m_since;
  logic [7:0]  m_prev, m_acc;
  bit          m_held, m_on, m_off, m_bad;

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 8; i++) if (c == CODES[i]) return i + 1;
    return 0;
  endfunction

  always @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      m_run = 1; m_prev = 8'hF0; m_acc = 8'hF0;
      m_held = 0; m_idx = 0; m_hp = 0; m_since = 0;
      m_on = 0; m_off = 0; m_bad = 0;
    end else begin
      int k;
      m_on = 0; m_off = 0; m_bad = 0;
      if (key_code == m_prev) m_run++;
      else begin m_run = 1; m_prev = key_code; end
      m_since++;
      if (m_run >= SC && key_code != m_acc) begin
        m_acc = key_code;
        k = lookup(key_code);
        if (key_code == 8'hF0) begin
          if (m_held) begin m_off = 1; m_held = 0; m_hp = 0; end
        end else if (k == 0) begin
          m_bad = 1;
        end else if (!m_held || k != m_idx) begin
          m_off = m_held; m_on = 1; m_held = 1;
          m_idx = k; m_hp = HPS[k-1]; m_since = 0;
        end
      end
    end
  end

  function automatic logic [24:0] exp_vec();
    bit t;
    t = m_held && (((m_since / m_hp) % 2) == 1);
    return {m_held, 4'(m_idx), m_on, m_off, m_bad, 16'(m_hp), t};
  endfunction

  function automatic logic [24:0] got_vec();
    return {note_valid, note_idx, note_on, note_off, bad_code, half_period, tone};
  endfunction

  task automatic test_reset();
    k_tr = 1'b0; key_code = 8'hF0;
    #25;
    checks++;
    if (got_vec() !== 25'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", got_vec()); end
    @(posedge clock); #1; k_tr = 1'b1;
    for (int s = 0; s < 20; s++) begin
      @(posedge clock); #1;
      checks++;
      if (got_vec() !== 25'd0 || got_vec() !== exp_vec()) begin
        errors++; $display("FAIL idle_f0 cyc=%0d got=%h exp=0", s, got_vec());
      end
    end
  endtask

  task automatic test_note_on();
    int strobes, rise_at;
    key_code = 8'h2B;
    for (int s = 1; s <= SC; s++) begin
      @(posedge clock); #1;
      checks++;
      if (note_on !== (s == SC) || got_vec() !== exp_vec()) begin
        errors++; $display("FAIL note_on_latency step=%0d got=%h exp=%h", s, got_vec(), exp_vec());
      end
    end
    checks++;
    if (note_idx !== 4'd1 || half_period !== 16'd47778 || note_valid !== 1'b1 || tone !== 1'b0) begin
      errors++; $display("FAIL note1_load idx=%0d hp=%0d vld=%b tone=%b exp 1 47778 1 0",
                         note_idx, half_period, note_valid, tone);
    end
    // A 3-sample glitch to 0x34 must neither strobe nor disturb the tone phase.
    strobes = 0; rise_at = -1;
    for (int c = 1; c <= 50000 && rise_at < 0; c++) begin
      @(posedge clock); #1;
      if (note_on || note_off || bad_code) strobes++;
      if (tone === 1'b1) rise_at = c;
      if (got_vec() !== exp_vec()) begin
        checks++; errors++;
        $display("FAIL note1_track cyc=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
      if (c == 100) key_code = 8'h34;
      if (c == 103) key_code = 8'h2B;
    end
    checks++;
    if (rise_at != 47778) begin errors++; $display("FAIL tone_rise got=%0d exp=47778", rise_at); end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL glitch_strobes got=%0d exp=0", strobes); end
  endtask

  task automatic test_async_reset();
    checks++;
    if (tone !== 1'b1) begin errors++; $display("FAIL pre_reset_tone got=%b exp=1", tone); end
    key_code = 8'h42;
    #1 k_tr = 1'b0;
    #1;
    checks++;
    if (got_vec() !== 25'd0) begin errors++; $display("FAIL async_reset got=%h exp=0", got_vec()); end
    @(posedge clock); @(posedge clock); #1;
    checks++;
    if (got_vec() !== 25'd0) begin errors++; $display("FAIL reset_hold got=%h exp=0", got_vec()); end
    k_tr = 1'b1;
    for (int s = 1; s <= SC; s++) begin
      @(posedge clock); #1;
      checks++;
      if (note_on !== (s == SC) || note_off !== 1'b0 || got_vec() !== exp_vec()) begin
        errors++; $display("FAIL post_reset_on step=%0d got=%h exp=%h", s, got_vec(), exp_vec());
      end
    end
    checks++;
    if (note_idx !== 4'd5 || half_period !== 16'd31888) begin
      errors++; $display("FAIL post_reset_note idx=%0d hp=%0d exp 5 31888", note_idx, half_period);
    end
  endtask

  task automatic test_legato();
    int seen;
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      if (c == 0) key_code = 8'h3B;
      if (note_on === 1'b1) begin
        seen++;
        checks++;
        if (note_off !== 1'b1 || note_idx !== 4'd4 || half_period !== 16'd35793 || tone !== 1'b0) begin
          errors++; $display("FAIL legato off=%b idx=%0d hp=%0d tone=%b exp 1 4 35793 0",
                             note_off, note_idx, half_period, tone);
        end
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL legato_track cyc=%0d got=%h exp=%h", c, got_vec(), exp_vec());
      end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL legato_count got=%0d exp=1", seen); end
  endtask

  task automatic test_release_bad();
    int offs, bads;
    offs = 0; bads = 0;
    key_code = 8'hF0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (note_off === 1'b1) begin
        offs++;
        checks++;
        if (note_on !== 1'b0 || note_valid !== 1'b0 || half_period !== 16'd0 || tone !== 1'b0 || note_idx !== 4'd4) begin
          errors++; $display("FAIL release got=%h exp vld0 hp0 tone0 idx4", got_vec());
        end
      end
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL release_track got=%h exp=%h", got_vec(), exp_vec()); end
    end
    key_code = 8'h1C;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (bad_code === 1'b1) begin
        bads++;
        checks++;
        if (note_on !== 1'b0 || note_off !== 1'b0 || note_valid !== 1'b0 || note_idx !== 4'd4) begin
          errors++; $display("FAIL bad_code got=%h exp bad only idx4", got_vec());
        end
      end
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL bad_track got=%h exp=%h", got_vec(), exp_vec()); end
    end
    checks++;
    if (offs != 1 || bads != 1) begin errors++; $display("FAIL strobe_counts off=%0d bad=%0d exp 1 1", offs, bads); end
  endtask

  task automatic test_random();
    int kind, hold, strobes;
    strobes = 0;
    for (int seg = 0; seg < 400; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) key_code = CODES[$urandom_range(0, 7)];
      else if (kind <= 7) key_code = 8'hF0;
      else key_code = 8'($urandom_range(0, 255));
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        @(posedge clock); #1;
        if (m_on || m_off || m_bad) strobes++;
        checks++;
        if (got_vec() !== exp_vec()) begin
          errors++; $display("FAIL random seg=%0d code=%h got=%h exp=%h", seg, key_code, got_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (strobes == 0) begin errors++; $display("FAIL random_activity got=0 strobes exp>0"); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_async_reset();
    test_legato();
    test_release_bad();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_note_decoder.md
# key_note_decoder

Receiver for the synthesizer key-code stream. The note sequencer and the PS/2 keyboard path both drive this stream as an 8-bit level: a make code while a key is held, 0xF0 while released. This block filters the level for stability, tracks the single held note, and emits note-on/note-off strobes, the note index and its half-period. It also runs a square-wave tone generator that the audio path uses directly.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a key_code value is accepted; legal range 1..255.
- clock  in  1  system clock, 50 MHz, rising edge.
- k_tr  in  1  reset, asynchronous, active-low.
- key_code  in  8  key-code level, sampled every rising edge.
- note_valid  out  1  high while a mapped note is held.
- note_idx  out  4  current or last note, 1..8; 0 after reset.
- note_on  out  1  one-cycle strobe when a note starts or retriggers.
- note_off  out  1  one-cycle strobe when the held note ends.
- bad_code  out  1  one-cycle strobe when an unmapped code is accepted.
- half_period  out  16  clock cycles per tone half-period; 0 when idle.
- tone  out  1  square wave; 0 when idle.

## Operation
- Code map (make code -> note_idx, half_period):
  - 0x2B -> 1, 47778
  - 0x34 -> 2, 42566
  - 0x33 -> 3, 37922
  - 0x3B -> 4, 35793
  - 0x42 -> 5, 31888
  - 0x4B -> 6, 28409
  - 0x4C -> 7, 25310
  - 0x52 -> 8, 23889
  - These are C5..C6 at 50 MHz. 0xF0 means release. Every other value is unmapped.
- Stability filter:
  - Registers cand[7:0] and cnt[7:0].
  - When a sample differs from cand: cand takes the sample and cnt is cleared to 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES-1.
  - A value is accepted on the edge where cand has been sampled STABLE_CYCLES times in a row and cand differs from the last accepted value (acc).
  - acc is updated on that same edge, so each distinct stable value is accepted exactly once.
- State machine, states IDLE and HELD. Transitions on acceptance:
  - IDLE + mapped code -> HELD. Pulse note_on; load note_idx and half_period; set note_valid.
  - IDLE + 0xF0 -> IDLE. No strobe.
  - HELD + 0xF0 -> IDLE. Pulse note_off; clear note_valid, half_period and tone. note_idx keeps the last value.
  - HELD + different mapped code -> HELD (legato). Pulse note_off and note_on on the same edge; load the new note_idx and half_period.
  - Any state + unmapped code -> pulse bad_code. State, note_idx, half_period and tone are unchanged. acc takes the unmapped value, so a return to the held code does not retrigger.
- Tone generator:
  - 16-bit counter pcnt, running only in HELD.
  - When pcnt == half_period-1: pcnt clears to 0 and tone toggles.
  - Otherwise pcnt increments.
  - On every note_on edge, pcnt clears to 0 and tone clears to 0.
  - In IDLE, pcnt and tone are held at 0.

## Timing
- Reset values:
  - Outputs: all 0.
  - Internal: cand = acc = 0xF0, cnt = 0, state IDLE, pcnt = 0.
  - Reset takes effect immediately and asynchronously, including mid-note; tone goes to 0 without a note_off strobe.
- Latency:
  - key_code changes to a stable new value before edge E0.
  - Strobes and new outputs appear after edge E0+STABLE_CYCLES-1, i.e. after the STABLE_CYCLES-th matching sample.
  - With STABLE_CYCLES=1, outputs appear after E0.
- Strobes are exactly one cycle wide. Any two acceptances are at least STABLE_CYCLES cycles apart, so strobes never merge.
- A value stable for fewer than STABLE_CYCLES samples produces no acceptance and no strobe.
- First tone toggle comes half_period cycles after the note_on edge. Full period is 2*half_period cycles.
- The legato retrigger restarts the phase. tone is 0 on the cycle after note_on.

## Test plan
- Reset, key_code=0xF0 for 20 cycles -> no strobes; all outputs 0.
- key_code=0x2B held, STABLE_CYCLES=4 -> note_on on the 4th sample edge, note_idx=1, half_period=47778, note_valid=1. Then tone rises 47778 cycles later and falls 47778 cycles after that.
- Held note 1; key_code=0x34 for 3 cycles, then back to 0x2B -> no strobes, tone phase uninterrupted.
- Held note 1; key_code=0x3B stable -> note_off and note_on on the same edge; note_idx=4, half_period=35793, pcnt and tone restart from 0.
- Held note 4; key_code=0xF0 stable -> note_off; note_valid=0, half_period=0, tone=0, note_idx stays 4. Then key_code=0x1C stable -> bad_code only.
- k_tr pulsed low mid-note with tone=1 -> all outputs 0 asynchronously. After release, with key_code still 0x42, note_on after STABLE_CYCLES samples, note_idx=5.
